ikaopll_timinggen: RTL

IKAOPLL_TIMINGGEN -- requirements
Module: IKAOPLL_timinggen

---
 rtl/ikaopll_timinggen_pkg.sv | 31 +++
 rtl/ikaopll_timinggen.sv | 106 ++++++++++
 2 files changed

// File: rtl/ikaopll_timinggen_pkg.sv
// -----------------------------------------------------------------------------
// ikaopll_timinggen_pkg
// Shared timing constants for the IKAOPLL core: slot-cycle frame length,
// slot-cycle decode indices and the phiM divider phases that produce the
// phi1 positive/negative edge enables. Also provides the slot-cycle advance
// helper used by the timing generator.
// -----------------------------------------------------------------------------
package ikaopll_timinggen_pkg;

   typedef logic [4:0] cycle_t;

   // Frame is 18 phi1 cycles: octal 00..21.
   localparam int CYCLE_LAST_DEF = 17;

   // Slot-cycle decode indices.
   localparam int CYC_00 = 0;
   localparam int CYC_D3 = 3;
   localparam int CYC_D4 = 4;
   localparam int CYC_21 = 17;

   // phiM divider phases on which the phi1 enables fire.
   localparam int PHASE_PCEN = 1;
   localparam int PHASE_NCEN = 3;

   // Next slot-cycle index. Anything at or past the last index wraps to 0,
   // so an out-of-range value recovers on the next advance.
   function automatic cycle_t cycle_advance(input cycle_t c, input cycle_t last);
      return (c >= last) ? '0 : c + 5'd1;
   endfunction

endpackage

// File: rtl/ikaopll_timinggen.sv
// -----------------------------------------------------------------------------
// ikaopll_timinggen
// Derives the phi1 edge enables from the phiM clock enable, runs the 18-slot
// cycle counter, decodes the slot indices used by the LFO/envelope/phase
// stages and stretches the initial clear to the first frame boundary.
//
// Ports
//   i_EMUCLK        emulator master clock, all flops on its rising edge
//   i_IC            synchronous active-high initial clear
//   i_phiM_PCEN_n   active-low phiM clock enable (one i_EMUCLK wide)
//   o_phi1_PCEN_n   active-low phi1 positive-edge enable
//   o_phi1_NCEN_n   active-low phi1 negative-edge enable
//   o_IC_n          phi1-aligned active-low clear, released at first frame wrap
//   o_CYCLE_NUM     current slot-cycle index 0..CYCLE_LAST
//   o_CYCLE_00      index == 0
//   o_CYCLE_21      index == 17 (octal 21)
//   o_CYCLE_D4      index == 4
//   o_CYCLE_D3_ZZ   index-3 decode delayed two phi1 cycles (high at index 5)
// -----------------------------------------------------------------------------
module ikaopll_timinggen
   import ikaopll_timinggen_pkg::*;
#(
   parameter int CYCLE_LAST = CYCLE_LAST_DEF,
   parameter int PHIM_DIV   = 4
)(
   input  logic       i_EMUCLK,
   input  logic       i_IC,
   input  logic       i_phiM_PCEN_n,
   output logic       o_phi1_PCEN_n,
   output logic       o_phi1_NCEN_n,
   output logic       o_IC_n,
   output logic [4:0] o_CYCLE_NUM,
   output logic       o_CYCLE_00,
   output logic       o_CYCLE_21,
   output logic       o_CYCLE_D4,
   output logic       o_CYCLE_D3_ZZ
);

   localparam int DIV_W = (PHIM_DIV > 1) ? $clog2(PHIM_DIV) : 1;

   logic [DIV_W-1:0] div_reg;
   cycle_t           cycle_reg;
   cycle_t           cycle_next;
   logic             phim_en;
   logic             phi1_pcen;
   logic             phi1_ncen;
   logic             ic_n_reg;
   logic             cyc00_reg;
   logic             cyc21_reg;
   logic             cycd4_reg;
   logic             d3_z_reg;
   logic             d3_zz_reg;

   assign phim_en = ~i_phiM_PCEN_n;

   // The enables are combinational so they line up with the phiM enable that
   // causes them; gating with i_IC keeps them quiet on the first clear clock,
   // before the divider has been forced back to 0.
   assign phi1_pcen = phim_en & ~i_IC & (div_reg == DIV_W'(PHASE_PCEN));
   assign phi1_ncen = phim_en & ~i_IC & (div_reg == DIV_W'(PHASE_NCEN));

   assign cycle_next = cycle_advance(cycle_reg, 5'(CYCLE_LAST));

   always_ff @(posedge i_EMUCLK) begin
      if (i_IC) begin
         div_reg   <= '0;
         cycle_reg <= '0;
         ic_n_reg  <= 1'b0;
         cyc00_reg <= 1'b0;
         cyc21_reg <= 1'b0;
         cycd4_reg <= 1'b0;
         d3_z_reg  <= 1'b0;
         d3_zz_reg <= 1'b0;
      end else begin
         if (phim_en) begin
            div_reg <= div_reg + DIV_W'(1);
         end
         if (phi1_ncen) begin
            cycle_reg <= cycle_next;
            // Decodes use the next index so they change together with the counter.
            cyc00_reg <= (cycle_next == 5'(CYC_00));
            cyc21_reg <= (cycle_next == 5'(CYC_21));
            cycd4_reg <= (cycle_next == 5'(CYC_D4));
            // Two-stage delay of the index-3 decode: high at 4 in the first
            // stage, high at 5 in the second.
            d3_z_reg  <= (cycle_reg == 5'(CYC_D3));
            d3_zz_reg <= d3_z_reg;
            // Release the stretched clear at the first frame boundary; it then
            // stays released until the next i_IC.
            if (cycle_next == '0) begin
               ic_n_reg <= 1'b1;
            end
         end
      end
   end

   assign o_phi1_PCEN_n = ~phi1_pcen;
   assign o_phi1_NCEN_n = ~phi1_ncen;
   assign o_IC_n        = ic_n_reg;
   assign o_CYCLE_NUM   = cycle_reg;
   assign o_CYCLE_00    = cyc00_reg;
   assign o_CYCLE_21    = cyc21_reg;
   assign o_CYCLE_D4    = cycd4_reg;
   assign o_CYCLE_D3_ZZ = d3_zz_reg;

endmodule
